// File: rtl/chimera_cluster_pwr_seq.sv
// chimera_cluster_pwr_seq
// Per-cluster power sequencer. Turns a level power request into an ordered
// sequence on the cluster's clock gate, reset and AXI isolation.
//   Power-up  : clock on under reset -> reset release -> de-isolate.
//   Power-down: isolate and drain -> clock off -> reset.
// One FSM with one shared saturating down-counter. It times the reset hold,
// the clock-settle delay and the isolation-handshake timeout. All outputs are
// decoded from the registered state (Moore), so they never glitch on inputs.
`timescale 1ns/1ps

module chimera_cluster_pwr_seq #(
  parameter bit          IsolateEn       = 1'b1,
  parameter int unsigned RstCycles       = 8,
  parameter int unsigned ClkSettleCycles = 4,
  parameter int unsigned TimeoutCycles   = 1024
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pwr_req_i,
  input  logic       isolated_i,
  output logic       isolate_o,
  output logic       clk_en_o,
  output logic       cluster_rst_no,
  output logic       pwr_on_o,
  output logic       busy_o,
  output logic       drain_timeout_o,
  output logic [2:0] state_o
);

  // Counter width covers the longest of the three delays that share it.
  localparam int unsigned MaxA      = (RstCycles > ClkSettleCycles) ? RstCycles : ClkSettleCycles;
  localparam int unsigned MaxCycles = (MaxA > TimeoutCycles) ? MaxA : TimeoutCycles;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t RstLoad     = cnt_t'(RstCycles - 1);
  localparam cnt_t SettleLoad  = cnt_t'(ClkSettleCycles - 1);
  localparam cnt_t TimeoutLoad = cnt_t'(TimeoutCycles - 1);

  // State codes are visible through the cfg register, so they are fixed.
  typedef enum logic [2:0] {
    OFF       = 3'd0,
    PWRUP_RST = 3'd1,
    DEISO     = 3'd2,
    ACTIVE    = 3'd3,
    ISO       = 3'd4,
    CLK_OFF   = 3'd5
  } state_e;

  state_e state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  logic   timeout_q, timeout_d;

  // Isolation is considered complete when the stage reports it, or always
  // when isolation is disabled for this build.
  logic iso_done;
  logic deiso_done;

  assign iso_done   = isolated_i | ~IsolateEn;
  assign deiso_done = ~isolated_i | ~IsolateEn;

  // State, counter and sticky timeout flag; reset parks the cluster in OFF.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= OFF;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state, counter and timeout logic.
  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; an unassigned path in always_comb would infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;

    unique case (state_q)
      OFF: begin
        if (pwr_req_i) begin
          state_d   = PWRUP_RST;
          cnt_d     = RstLoad;
          timeout_d = 1'b0;
        end
      end

      // Request drops are ignored: the reset pulse always runs to completion.
      PWRUP_RST: begin
        if (cnt_q == '0) begin
          state_d = DEISO;
          cnt_d   = TimeoutLoad;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DEISO: begin
        if (deiso_done) begin
          state_d = ACTIVE;
        end else if (cnt_q == '0) begin
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ACTIVE: begin
        if (!pwr_req_i) begin
          state_d   = ISO;
          cnt_d     = TimeoutLoad;
          timeout_d = 1'b0;
        end
      end

      // A renewed request aborts the power-down even if the drain completes
      // in the same cycle; the clock is still running, so it is safe.
      ISO: begin
        if (pwr_req_i) begin
          state_d = DEISO;
          cnt_d   = TimeoutLoad;
        end else if (iso_done) begin
          state_d = CLK_OFF;
          cnt_d   = SettleLoad;
        end else if (cnt_q == '0) begin
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      // Requests are ignored until the cluster is fully back in OFF.
      CLK_OFF: begin
        if (cnt_q == '0) begin
          state_d = OFF;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = OFF;
        cnt_d   = '0;
      end
    endcase
  end

  // Moore output decode from the registered state.
  always_comb begin
    clk_en_o       = 1'b0;
    cluster_rst_no = 1'b0;
    isolate_o      = IsolateEn;
    pwr_on_o       = 1'b0;
    busy_o         = 1'b1;

    unique case (state_q)
      OFF: begin
        busy_o = 1'b0;
      end
      PWRUP_RST: begin
        clk_en_o = 1'b1;
      end
      DEISO: begin
        clk_en_o       = 1'b1;
        cluster_rst_no = 1'b1;
        isolate_o      = 1'b0;
      end
      ACTIVE: begin
        clk_en_o       = 1'b1;
        cluster_rst_no = 1'b1;
        isolate_o      = 1'b0;
        pwr_on_o       = 1'b1;
        busy_o         = 1'b0;
      end
      ISO: begin
        clk_en_o       = 1'b1;
        cluster_rst_no = 1'b1;
      end
      CLK_OFF: begin
        cluster_rst_no = 1'b1;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  assign drain_timeout_o = timeout_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_chimera_cluster_pwr_seq.sv
// Testbench for chimera_cluster_pwr_seq: vector table, hand-written corner
// sequences, and randomized traffic compared against a behavioural model.
`timescale 1ns/1ps

module tb_chimera_cluster_pwr_seq;

  localparam int RST_CYC    = 8;
  localparam int SETTLE_CYC = 4;
  localparam int TO_CYC     = 16;

  logic clk_i = 1'b0;
  logic rst_ni;

  // Main instance (isolation enabled)
  logic       req, iso;
  logic       m_isolate, m_clk_en, m_rst_n, m_pwr_on, m_busy, m_to;
  logic [2:0] m_state;

  // Bypass instance (isolation disabled)
  logic       req_b;
  logic       b_isolate, b_clk_en, b_rst_n, b_pwr_on, b_busy, b_to;
  logic [2:0] b_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  chimera_cluster_pwr_seq #(
    .IsolateEn(1'b1), .RstCycles(RST_CYC), .ClkSettleCycles(SETTLE_CYC), .TimeoutCycles(TO_CYC)
  ) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .pwr_req_i(req), .isolated_i(iso),
    .isolate_o(m_isolate), .clk_en_o(m_clk_en), .cluster_rst_no(m_rst_n),
    .pwr_on_o(m_pwr_on), .busy_o(m_busy), .drain_timeout_o(m_to), .state_o(m_state)
  );

  chimera_cluster_pwr_seq #(
    .IsolateEn(1'b0), .RstCycles(RST_CYC), .ClkSettleCycles(SETTLE_CYC), .TimeoutCycles(TO_CYC)
  ) u_byp (
    .clk_i(clk_i), .rst_ni(rst_ni), .pwr_req_i(req_b), .isolated_i(1'b0),
    .isolate_o(b_isolate), .clk_en_o(b_clk_en), .cluster_rst_no(b_rst_n),
    .pwr_on_o(b_pwr_on), .busy_o(b_busy), .drain_timeout_o(b_to), .state_o(b_state)
  );

  // ---------------------------------------------------------------- helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  function automatic logic [8:0] pack_m();
    return {m_state, m_clk_en, m_rst_n, m_isolate, m_pwr_on, m_busy, m_to};
  endfunction

  function automatic logic [8:0] pack_b();
    return {b_state, b_clk_en, b_rst_n, b_isolate, b_pwr_on, b_busy, b_to};
  endfunction

  // Expected output vector for a state code, from the decode table.
  function automatic logic [8:0] exp_vec(input int code, input bit to, input bit isoen);
    logic [2:0] c;
    logic [2:0] cri;
    c = code[2:0];
    case (code)
      0:       cri = 3'b001;
      1:       cri = 3'b101;
      2:       cri = 3'b110;
      3:       cri = 3'b110;
      4:       cri = 3'b111;
      5:       cri = 3'b011;
      default: cri = 3'b000;
    endcase
    cri[0] = cri[0] & isoen;
    return {c, cri, (code == 3), (code != 0 && code != 3), to};
  endfunction

  // Behavioural model: phase plus cycles spent in that phase.
  typedef enum int {P_OFF = 0, P_PWRUP = 1, P_DEISO = 2, P_ACTIVE = 3, P_ISO = 4, P_CLKOFF = 5} phase_e;
  typedef struct {
    phase_e ph;
    int     el;
    bit     to;
  } mdl_t;

  function automatic mdl_t mdl_step(input mdl_t m, input bit r, input bit i, input bit isoen);
    mdl_t n;
    n = m;
    case (m.ph)
      P_OFF:    if (r) begin n.ph = P_PWRUP; n.el = 0; n.to = 0; end
      P_PWRUP: begin
        n.el = m.el + 1;
        if (n.el == RST_CYC) begin n.ph = P_DEISO; n.el = 0; end
      end
      P_DEISO: begin
        if (!i || !isoen) begin n.ph = P_ACTIVE; n.el = 0; end
        else begin
          n.el = (m.el < TO_CYC) ? m.el + 1 : m.el;
          if (n.el >= TO_CYC) n.to = 1;
        end
      end
      P_ACTIVE: if (!r) begin n.ph = P_ISO; n.el = 0; n.to = 0; end
      P_ISO: begin
        if (r) begin n.ph = P_DEISO; n.el = 0; end
        else if (i || !isoen) begin n.ph = P_CLKOFF; n.el = 0; end
        else begin
          n.el = (m.el < TO_CYC) ? m.el + 1 : m.el;
          if (n.el >= TO_CYC) n.to = 1;
        end
      end
      P_CLKOFF: begin
        n.el = m.el + 1;
        if (n.el == SETTLE_CYC) begin n.ph = P_OFF; n.el = 0; end
      end
      default: n.ph = P_OFF;
    endcase
    return n;
  endfunction

  task automatic do_reset();
    rst_ni = 1'b0;
    repeat (2) tick();
    #1 rst_ni = 1'b1;
  endtask

  task automatic wait_main(input logic [2:0] st, input int max, input string name);
    int k;
    k = 0;
    while (m_state !== st && k < max) begin
      tick();
      k++;
    end
    check(name, m_state, st);
  endtask

  // Assert reset between edges and require reset outputs before the next edge.
  task automatic async_reset_check(input string name);
    #2 rst_ni = 1'b0;
    #1;
    check({name, "_main"}, pack_m(), exp_vec(0, 0, 1));
    check({name, "_byp"},  pack_b(), exp_vec(0, 0, 0));
    tick();
    tick();
    #1 rst_ni = 1'b1;
  endtask

  // ---------------------------------------------------------- invariants
  logic pm_clk = 1'b0, pm_rst = 1'b0, pb_clk = 1'b0, pb_rst = 1'b0;

  always @(negedge clk_i) begin
    if (rst_ni === 1'b1) begin
      if (!pm_clk && m_clk_en)  check("inv_clk_rise_main", m_rst_n, 0);
      if (pm_rst && !m_rst_n)   check("inv_rst_fall_main", m_clk_en, 0);
      if (!m_isolate)           check("inv_iso_main", {m_clk_en, m_rst_n}, 2'b11);
      if (!pb_clk && b_clk_en)  check("inv_clk_rise_byp", b_rst_n, 0);
      if (pb_rst && !b_rst_n)   check("inv_rst_fall_byp", b_clk_en, 0);
    end
    pm_clk <= m_clk_en;
    pm_rst <= m_rst_n;
    pb_clk <= b_clk_en;
    pb_rst <= b_rst_n;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------- vector table
  typedef struct {
    bit req;
    bit iso;
    int n;
    int st;
    bit to;
  } vec_t;

  vec_t tbl [13];

  initial begin
    mdl_t mm, mb;
    int   up_clk, up_rst, up_on, ticks, stuck_left;
    bit   byp_iso_seen;
    logic lagq [$];

    tbl[0]  = '{1'b0, 1'b1, 3, 0, 1'b0};  // idle in OFF
    tbl[1]  = '{1'b1, 1'b1, 1, 1, 1'b0};  // request -> PWRUP_RST
    tbl[2]  = '{1'b0, 1'b1, 7, 1, 1'b0};  // request drop ignored
    tbl[3]  = '{1'b1, 1'b1, 1, 2, 1'b0};  // RstCycles reached -> DEISO
    tbl[4]  = '{1'b1, 1'b1, 2, 2, 1'b0};  // still isolated
    tbl[5]  = '{1'b1, 1'b0, 1, 3, 1'b0};  // de-isolated -> ACTIVE
    tbl[6]  = '{1'b1, 1'b0, 3, 3, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1, 4, 1'b0};  // drop -> ISO
    tbl[8]  = '{1'b0, 1'b0, 5, 4, 1'b0};  // draining
    tbl[9]  = '{1'b0, 1'b1, 1, 5, 1'b0};  // drained -> CLK_OFF
    tbl[10] = '{1'b1, 1'b1, 3, 5, 1'b0};  // request ignored in CLK_OFF
    tbl[11] = '{1'b1, 1'b1, 1, 0, 1'b0};  // settle done -> OFF
    tbl[12] = '{1'b1, 1'b1, 1, 1, 1'b0};  // pending request starts again

    // Reset values, observed before any clock edge
    rst_ni = 1'b0;
    req = 1'b0; iso = 1'b1; req_b = 1'b0;
    #1;
    check("reset_main", pack_m(), exp_vec(0, 0, 1));
    check("reset_byp",  pack_b(), exp_vec(0, 0, 0));
    tick();
    #1 rst_ni = 1'b1;

    for (int i = 0; i < 13; i++) begin
      req = tbl[i].req;
      iso = tbl[i].iso;
      repeat (tbl[i].n) tick();
      check($sformatf("vec%0d", i), pack_m(), exp_vec(tbl[i].st, tbl[i].to, 1));
    end

    // Power-up: isolated_i follows isolate_o with a 2-cycle lag
    req = 1'b0; iso = 1'b1;
    do_reset();
    repeat (10) tick();
    up_clk = -1; up_rst = -1; up_on = -1;
    lagq = {1'b1, 1'b1};
    req = 1'b1;
    for (int k = 0; k < 40 && up_on < 0; k++) begin
      tick();
      if (up_clk < 0 && m_clk_en) up_clk = k;
      if (up_rst < 0 && m_rst_n)  up_rst = k;
      if (up_on < 0 && m_pwr_on)  up_on  = k;
      lagq.push_back(m_isolate);
      iso = lagq.pop_front();
    end
    check("pu_clk_en_edge", up_clk, 0);
    check("pu_rst_rel_edge", up_rst, RST_CYC);
    check("pu_pwr_on_edge", up_on, RST_CYC + 3);

    // Power-down: isolated_i rises 3 cycles after isolate_o
    iso = 1'b0;
    req = 1'b0;
    tick();
    check("pd_iso_state", m_state, 4);
    repeat (2) tick();
    iso = 1'b1;
    tick();
    check("pd_clk_off", {m_state, m_clk_en}, {3'd5, 1'b0});
    repeat (SETTLE_CYC - 1) tick();
    check("pd_rst_held", m_rst_n, 1);
    tick();
    check("pd_rst_asserted", m_rst_n, 0);
    check("pd_state_off", m_state, 0);

    // Abort: renewed request and isolated_i in the same ISO cycle
    req = 1'b1; iso = 1'b1;
    wait_main(3'd2, 20, "ab_reach_deiso");
    iso = 1'b0;
    wait_main(3'd3, 5, "ab_reach_active");
    req = 1'b0;
    tick();
    check("ab_in_iso", {m_state, m_clk_en}, {3'd4, 1'b1});
    req = 1'b1; iso = 1'b1;
    tick();
    check("ab_to_deiso", {m_state, m_clk_en}, {3'd2, 1'b1});
    iso = 1'b0;
    tick();
    check("ab_back_active", {m_state, m_clk_en}, {3'd3, 1'b1});

    // Timeout: hold isolated_i low in ISO
    req = 1'b0; iso = 1'b0;
    tick();
    repeat (TO_CYC - 1) tick();
    check("to_not_yet", {m_state, m_to}, {3'd4, 1'b0});
    tick();
    check("to_set", {m_state, m_to}, {3'd4, 1'b1});
    repeat (5) tick();
    check("to_holds", {m_state, m_to}, {3'd4, 1'b1});
    iso = 1'b1;
    wait_main(3'd0, 10, "to_power_down_done");
    check("to_sticky_in_off", m_to, 1);
    req = 1'b1;
    tick();
    check("to_cleared_on_pwrup", {m_state, m_to}, {3'd1, 1'b0});

    // Async reset mid-PWRUP_RST, mid-ISO, mid-CLK_OFF
    repeat (3) tick();
    check("ar_pre_pwrup", m_state, 1);
    async_reset_check("ar_pwrup");
    req = 1'b1; iso = 1'b1;
    wait_main(3'd2, 20, "ar_reach_deiso");
    iso = 1'b0;
    wait_main(3'd3, 5, "ar_reach_active");
    req = 1'b0;
    repeat (4) tick();
    check("ar_pre_iso", m_state, 4);
    async_reset_check("ar_iso");
    req = 1'b1;
    iso = 1'b1;
    wait_main(3'd2, 20, "ar_reach_deiso2");
    iso = 1'b0;
    wait_main(3'd3, 5, "ar_reach_active2");
    req = 1'b0;
    tick();
    iso = 1'b1;
    tick();
    tick();
    check("ar_pre_clkoff", m_state, 5);
    async_reset_check("ar_clkoff");
    tick();
    check("ar_stays_off", pack_m(), exp_vec(0, 0, 1));

    // Bypass instance: full up/down cycle, isolated_i tied 0
    byp_iso_seen = 1'b0;
    req_b = 1'b1;
    ticks = 0;
    while (!b_pwr_on && ticks < 40) begin
      tick();
      ticks++;
      byp_iso_seen |= b_isolate;
    end
    check("byp_up_latency", ticks - 1, 9);
    req_b = 1'b0;
    tick();
    check("byp_iso_state", b_state, 4);
    ticks = 1;
    while (b_state != 3'd0 && ticks < 40) begin
      tick();
      ticks++;
      byp_iso_seen |= b_isolate;
    end
    check("byp_down_latency", ticks - 1, 5);
    check("byp_isolate_low", byp_iso_seen, 0);

    // Randomized traffic against the model
    req = 1'b0; iso = 1'b1; req_b = 1'b0;
    do_reset();
    mm = '{P_OFF, 0, 1'b0};
    mb = '{P_OFF, 0, 1'b0};
    stuck_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) req   = ~req;
      if ($urandom_range(0, 15) == 0) req_b = ~req_b;
      if (stuck_left > 0) stuck_left--;
      else if ($urandom_range(0, 99) == 0) stuck_left = $urandom_range(10, 30);
      else if ($urandom_range(0, 2) == 0) iso = m_isolate;
      else if ($urandom_range(0, 19) == 0) iso = ~iso;

      if ($urandom_range(0, 299) == 0) begin
        #2 rst_ni = 1'b0;
        mm = '{P_OFF, 0, 1'b0};
        mb = '{P_OFF, 0, 1'b0};
        @(negedge clk_i);
        #1 rst_ni = 1'b1;
      end else begin
        @(posedge clk_i);
        mm = mdl_step(mm, req, iso, 1'b1);
        mb = mdl_step(mb, req_b, 1'b0, 1'b0);
        @(negedge clk_i);
      end
      check("rand_main", pack_m(), exp_vec(int'(mm.ph), mm.to, 1'b1));
      check("rand_byp",  pack_b(), exp_vec(int'(mb.ph), mb.to, 1'b0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
